// File: rtl/watchdog_ctrl.sv
// Watchdog controller: down-counter sequencing IDLE/RUN/WARN/EXPIRED with a 4-register config port.
// Optional tick prescaler is built when WDT_PRESCALER_EN is defined.
module watchdog_ctrl #(
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    output logic [CNT_W-1:0] cfg_rdata,
    input  logic             kick,
    input  logic             halt,
    output logic             warn_irq,
    output logic             expired,
    output logic             sys_reset_req,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WARN    = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  r_timeout;
    logic [CNT_W-1:0]  w_timeout_nxt;
    logic [CNT_W-1:0]  r_warn;
    logic [CNT_W-1:0]  w_warn_nxt;
    logic [CNT_W-1:0]  w_dec;
    logic              r_en;
    logic              w_en_nxt;
    logic              r_lock;
    logic              r_expired;
    logic              r_warn_irq;
    logic              r_sys_reset_req;
    logic              w_ctrl_wr;
    logic              w_clr;
    logic              w_tick;
    logic              w_pre_clr;

    assign w_ctrl_wr = cfg_we && (cfg_addr == 2'd0);
    assign w_clr     = w_ctrl_wr && cfg_wdata[2];
    assign w_dec     = (r_count == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (r_count - CNT_W'(1));

`ifdef WDT_PRESCALER_EN
    localparam int PRE_W = $clog2(PRESCALE);
    logic [PRE_W-1:0] r_pre;

    assign w_tick = !halt && (r_pre == PRE_W'(PRESCALE - 1));

    // Prescaler: counts non-halted cycles, wraps on tick, zeroed on kick/enable/clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= {PRE_W{1'b0}};
        end else if (w_pre_clr) begin
            r_pre <= {PRE_W{1'b0}};
        end else if (halt) begin
            r_pre <= r_pre;
        end else if (w_tick) begin
            r_pre <= {PRE_W{1'b0}};
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end
`else
    logic [32:0] w_unused_prescale;
    assign w_unused_prescale = {w_pre_clr, 32'(PRESCALE)};
    assign w_tick            = !halt;
`endif

    // Config register next values; lock freezes en/TIMEOUT/WARN but never clr
    always_comb begin
        w_timeout_nxt = r_timeout;
        w_warn_nxt    = r_warn;
        w_en_nxt      = r_en;
        if (cfg_we && (cfg_addr == 2'd1) && !r_lock) begin
            w_timeout_nxt = cfg_wdata;
        end else begin
            w_timeout_nxt = r_timeout;
        end
        if (cfg_we && (cfg_addr == 2'd2) && !r_lock) begin
            w_warn_nxt = cfg_wdata;
        end else begin
            w_warn_nxt = r_warn;
        end
        if (w_clr && (r_state == ST_EXPIRED)) begin
            w_en_nxt = 1'b0;
        end else if (w_ctrl_wr && !r_lock) begin
            w_en_nxt = cfg_wdata[0];
        end else begin
            w_en_nxt = r_en;
        end
    end

    // Next-state and next-count: kick outranks an expiring tick, reload sees a same-cycle TIMEOUT write
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pre_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_count_nxt = w_timeout_nxt;
                w_pre_clr   = 1'b1;
                if (w_en_nxt) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN, ST_WARN: begin
                if (!w_en_nxt) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = w_timeout_nxt;
                end else if (kick) begin
                    w_state_nxt = ST_RUN;
                    w_count_nxt = w_timeout_nxt;
                    w_pre_clr   = 1'b1;
                end else if (w_tick) begin
                    if ((r_state == ST_WARN) && (r_count == {CNT_W{1'b0}})) begin
                        w_state_nxt = ST_EXPIRED;
                        w_count_nxt = {CNT_W{1'b0}};
                    end else if (w_dec <= r_warn) begin
                        w_state_nxt = ST_WARN;
                        w_count_nxt = w_dec;
                    end else begin
                        w_state_nxt = r_state;
                        w_count_nxt = w_dec;
                    end
                end else begin
                    w_state_nxt = r_state;
                    w_count_nxt = r_count;
                end
            end
            ST_EXPIRED: begin
                if (w_clr) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = w_timeout_nxt;
                    w_pre_clr   = 1'b1;
                end else begin
                    w_state_nxt = ST_EXPIRED;
                    w_count_nxt = {CNT_W{1'b0}};
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, configuration and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_count         <= {CNT_W{1'b0}};
            r_timeout       <= {CNT_W{1'b1}};
            r_warn          <= CNT_W'(16);
            r_en            <= 1'b0;
            r_lock          <= 1'b0;
            r_expired       <= 1'b0;
            r_warn_irq      <= 1'b0;
            r_sys_reset_req <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_count         <= w_count_nxt;
            r_timeout       <= w_timeout_nxt;
            r_warn          <= w_warn_nxt;
            r_en            <= w_en_nxt;
            r_lock          <= r_lock | (w_ctrl_wr & cfg_wdata[1]);
            r_expired       <= (w_state_nxt == ST_EXPIRED);
            r_warn_irq      <= (w_state_nxt == ST_WARN);
            r_sys_reset_req <= (w_state_nxt == ST_EXPIRED) && (r_state != ST_EXPIRED);
        end
    end

    // Zero-latency register read
    always_comb begin
        cfg_rdata = {CNT_W{1'b0}};
        case (cfg_addr)
            2'd0:    cfg_rdata = {{(CNT_W-3){1'b0}}, r_expired, r_lock, r_en};
            2'd1:    cfg_rdata = r_timeout;
            2'd2:    cfg_rdata = r_warn;
            2'd3:    cfg_rdata = r_count;
            default: cfg_rdata = {CNT_W{1'b0}};
        endcase
    end

    assign warn_irq      = r_warn_irq;
    assign expired       = r_expired;
    assign sys_reset_req = r_sys_reset_req;
    assign state_o       = r_state;

endmodule

// File: tb/tb_watchdog_ctrl.sv
// Directed self-checking bench for watchdog_ctrl (default build, no prescaler).
module tb_watchdog_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        kick;
    logic        halt;
    logic        warn_irq;
    logic        expired;
    logic        sys_reset_req;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    watchdog_ctrl #(.CNT_W(16), .PRESCALE(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .kick(kick), .halt(halt),
        .warn_irq(warn_irq), .expired(expired), .sys_reset_req(sys_reset_req),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
        cfg_addr = a;
        #1;
        check(tag, {16'h0, cfg_rdata}, {16'h0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] min_cnt;
        int          n_warn;
        int          n_exp;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0; kick = 1'b0; halt = 1'b0;
        repeat (2) step();
        check("rst_state", state_o, 2'd0);
        check("rst_warn_irq", warn_irq, 1'b0);
        check("rst_expired", expired, 1'b0);
        check("rst_sysreq", sys_reset_req, 1'b0);
        rd(2'd3, 16'h0000, "rst_count");
        rd(2'd1, 16'hFFFF, "rst_timeout");
        rd(2'd2, 16'h0010, "rst_warn");
        rd(2'd0, 16'h0000, "rst_ctrl");
        rst = 1'b0;
        step();
        rd(2'd3, 16'hFFFF, "idle_mirror");

        // basic expiry, TIMEOUT=10 WARN=3
        wr(2'd1, 16'd10);
        wr(2'd2, 16'd3);
        rd(2'd3, 16'd10, "idle_mirror_10");
        wr(2'd0, 16'h0001);
        check("run_entry_state", state_o, 2'd1);
        rd(2'd3, 16'd10, "run_entry_count");
        repeat (6) step();
        check("tick6_state", state_o, 2'd1);
        rd(2'd3, 16'd4, "tick6_count");
        step();
        check("tick7_state", state_o, 2'd2);
        check("tick7_warn_irq", warn_irq, 1'b1);
        rd(2'd3, 16'd3, "tick7_count");
        repeat (3) step();
        rd(2'd3, 16'd0, "tick10_count");
        check("tick10_state", state_o, 2'd2);
        check("tick10_sysreq", sys_reset_req, 1'b0);
        step();
        check("tick11_state", state_o, 2'd3);
        check("tick11_sysreq", sys_reset_req, 1'b1);
        check("tick11_expired", expired, 1'b1);
        check("tick11_warn_irq", warn_irq, 1'b0);
        step();
        check("sysreq_one_cycle", sys_reset_req, 1'b0);
        check("expired_sticky", expired, 1'b1);
        kick = 1'b1; step(); kick = 1'b0;
        check("exp_kick_ignored", state_o, 2'd3);
        rd(2'd0, 16'h0005, "exp_ctrl_read");
        wr(2'd0, 16'h0004);
        check("clr_state", state_o, 2'd0);
        check("clr_expired", expired, 1'b0);
        rd(2'd0, 16'h0000, "clr_ctrl_read");
        rd(2'd3, 16'd10, "clr_count_mirror");

        // kick service every 5 cycles for 100 cycles
        wr(2'd0, 16'h0001);
        cfg_addr = 2'd3;
        min_cnt = 16'hFFFF; n_warn = 0; n_exp = 0;
        for (int i = 0; i < 100; i++) begin
            kick = ((i % 5) == 4);
            step();
            kick = 1'b0;
            if (cfg_rdata < min_cnt) min_cnt = cfg_rdata;
            if (state_o == 2'd2) n_warn++;
            if (expired) n_exp++;
        end
        check("svc_min_count", {16'h0, min_cnt}, 32'd6);
        check("svc_warn_cycles", n_warn, 32'd0);
        check("svc_expired_cycles", n_exp, 32'd0);
        rd(2'd3, 16'd10, "svc_end_count");

        // kick from WARN at count 1, then kick coincident with expiring tick
        repeat (7) step();
        check("kw_warn_state", state_o, 2'd2);
        repeat (2) step();
        rd(2'd3, 16'd1, "kw_count1");
        kick = 1'b1; step(); kick = 1'b0;
        check("kw_state_run", state_o, 2'd1);
        check("kw_warn_irq", warn_irq, 1'b0);
        rd(2'd3, 16'd10, "kw_reload");
        repeat (10) step();
        rd(2'd3, 16'd0, "kz_count0");
        check("kz_warn_state", state_o, 2'd2);
        kick = 1'b1; step(); kick = 1'b0;
        check("kz_state_run", state_o, 2'd1);
        check("kz_sysreq", sys_reset_req, 1'b0);
        check("kz_expired", expired, 1'b0);
        rd(2'd3, 16'd10, "kz_reload");

        // lock
        wr(2'd0, 16'h0003);
        wr(2'd1, 16'd5);
        wr(2'd0, 16'h0000);
        rd(2'd1, 16'd10, "lock_timeout");
        check("lock_state_run", state_o, 2'd1);
        rd(2'd0, 16'h0003, "lock_ctrl");
        for (int i = 0; i < 40 && state_o != 2'd3; i++) step();
        check("lock_expire_reached", state_o, 2'd3);
        rd(2'd0, 16'h0007, "lock_exp_ctrl");
        wr(2'd0, 16'h0004);
        check("lock_clr_state", state_o, 2'd0);
        check("lock_clr_expired", expired, 1'b0);
        rd(2'd0, 16'h0002, "lock_clr_ctrl");

        rst = 1'b1;
        #1;
        check("rst2_state", state_o, 2'd0);
        rd(2'd0, 16'h0000, "rst2_ctrl");
        step();
        rst = 1'b0;

        // halt freezes counting
        wr(2'd1, 16'd10);
        wr(2'd2, 16'd3);
        wr(2'd0, 16'h0001);
        repeat (2) step();
        rd(2'd3, 16'd8, "halt_before");
        halt = 1'b1;
        repeat (20) step();
        rd(2'd3, 16'd8, "halt_held");
        check("halt_state", state_o, 2'd1);
        halt = 1'b0;
        step();
        rd(2'd3, 16'd7, "halt_released");

        // async reset mid-WARN
        repeat (4) step();
        check("mw_state", state_o, 2'd2);
        rst = 1'b1;
        #1;
        check("mw_rst_state", state_o, 2'd0);
        check("mw_rst_warn_irq", warn_irq, 1'b0);
        check("mw_rst_sysreq", sys_reset_req, 1'b0);
        check("mw_rst_expired", expired, 1'b0);
        rd(2'd3, 16'h0000, "mw_rst_count");
        rd(2'd1, 16'hFFFF, "mw_rst_timeout");
        step();
        check("mw_rst_sysreq_edge", sys_reset_req, 1'b0);
        rst = 1'b0;

        // en cleared in RUN
        wr(2'd1, 16'd10);
        wr(2'd0, 16'h0001);
        check("enclr_run", state_o, 2'd1);
        wr(2'd0, 16'h0000);
        check("enclr_idle", state_o, 2'd0);

        // TIMEOUT=0
        wr(2'd1, 16'd0);
        wr(2'd0, 16'h0001);
        rd(2'd3, 16'd0, "t0_count");
        check("t0_run", state_o, 2'd1);
        step();
        check("t0_warn", state_o, 2'd2);
        step();
        check("t0_expired", state_o, 2'd3);
        check("t0_sysreq", sys_reset_req, 1'b1);

        // kick coincident with TIMEOUT write uses the new value
        wr(2'd0, 16'h0004);
        wr(2'd1, 16'd10);
        wr(2'd0, 16'h0001);
        step();
        rd(2'd3, 16'd9, "kt_before");
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'd20; kick = 1'b1;
        step();
        cfg_we = 1'b0; kick = 1'b0;
        rd(2'd3, 16'd20, "kt_reload_new");
        check("kt_state", state_o, 2'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/watchdog_ctrl.md
Name: watchdog_ctrl

Overview:
- Synthesizable watchdog controller for the microISA-16 system. It is the hardware counterpart of the bench timeout watchdog.
- Sequences a down-counter through idle, run, warn and expired phases. Software kicks the counter through a small 4-register config port.
- Raises a warn interrupt before expiry. On expiry it pulses a one-cycle system reset request and keeps a sticky expired flag.

Parameters:
- CNT_W, 16, counter, TIMEOUT and WARN register width (matches the 16-bit data path).
- PRESCALE, 16, core cycles per watchdog tick. Used only when WDT_PRESCALER_EN is defined; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  register write strobe, single cycle.
- cfg_addr  in  2  register select: 0 CTRL, 1 TIMEOUT, 2 WARN, 3 COUNT (read-only).
- cfg_wdata  in  CNT_W  write data.
- cfg_rdata  out  CNT_W  combinational read of the register at cfg_addr.
- kick  in  1  reload request, sampled at clk.
- halt  in  1  debug freeze; counter and prescaler hold while high.
- warn_irq  out  1  level, high while in WARN.
- expired  out  1  sticky expired flag.
- sys_reset_req  out  1  one-cycle pulse on entry to EXPIRED.
- state_o  out  2  current state: IDLE=0, RUN=1, WARN=2, EXPIRED=3.

Behaviour:
- Reset (async assert, all registered values):
  - state IDLE; count=0; TIMEOUT=16'hFFFF; WARN=16'h0010.
  - CTRL en=0, lock=0; expired=0; warn_irq=0; sys_reset_req=0; prescaler=0.
  - Reset asserted mid-countdown aborts immediately, with no reset request.
- CTRL fields:
  - Write bits: bit0 en, bit1 lock (write-1 sets, clears only on rst), bit2 clr (write-1, self-clearing, not stored).
  - Read value: {13'b0, expired, lock, en}.
- Lock:
  - When lock=1, writes to en, TIMEOUT and WARN are ignored.
  - clr is still honoured under lock.
- tick: 1 every cycle without the macro, gated by !halt.
- IDLE:
  - count continuously mirrors TIMEOUT.
  - Writing en=1 moves to RUN next cycle, with count=TIMEOUT.
  - kick is ignored.
- RUN:
  - On tick, count decrements by 1.
  - kick reloads count=TIMEOUT next cycle and resets the prescaler.
  - When the next count <= WARN, go to WARN. If WARN >= TIMEOUT, WARN is entered on the first tick.
- WARN:
  - warn_irq=1.
  - kick reloads count and returns to RUN.
  - tick with count==0 goes to EXPIRED.
- EXPIRED:
  - expired=1 and count held at 0.
  - sys_reset_req is high for exactly the entry cycle.
  - A CTRL write with clr=1 clears expired and en and goes to IDLE. A kick does nothing.
- en cleared (unlocked) while in RUN or WARN: go to IDLE next cycle, warn_irq drops.
- Simultaneous events:
  - kick and expiring tick in the same cycle: kick wins, reload to RUN.
  - kick and a cfg TIMEOUT write in the same cycle: reload uses the new TIMEOUT.
- Arithmetic:
  - count never wraps: it stops at 0, and a decrement below 0 is impossible because 0 plus a tick means expire.
  - TIMEOUT=0 with en: WARN on the first tick (0 <= WARN), EXPIRED on the second tick.
- Latency: all state and count updates take effect 1 cycle after the sampled edge. cfg_rdata has zero cycles of latency.

Optional Feature:
- Macro: WDT_PRESCALER_EN.
- Defined:
  - A log2(PRESCALE)-bit prescaler counts non-halted cycles.
  - tick=1 only when the prescaler equals PRESCALE-1, then the prescaler wraps to 0.
  - kick, en-rising and clr zero the prescaler.
- Undefined: there is no prescaler logic, the PRESCALE parameter is unused, and tick=!halt.

Test Plan:
- Basic expiry: TIMEOUT=10, WARN=3, en=1, no kick, no macro -> warn_irq rises 7 ticks after RUN entry, EXPIRED 11 ticks after, sys_reset_req high exactly 1 cycle, expired stays 1.
- Kick service: TIMEOUT=10, WARN=3, kick every 5 cycles for 100 cycles -> never WARN, COUNT read never below 5, expired=0.
- Kick from WARN: kick in the cycle count==1 in WARN -> RUN, count=10, warn_irq=0 next cycle. A kick coincident with the count==0 tick also reloads, with no sys_reset_req.
- Lock: set en+lock, write TIMEOUT=5 and en=0 -> TIMEOUT reads 10, state stays RUN. clr after expiry -> IDLE, expired=0.
- Halt and reset mid-run: halt held for 20 cycles in RUN -> COUNT unchanged. Assert rst mid-WARN -> outputs reach reset values immediately, no sys_reset_req.
- Prescaler (WDT_PRESCALER_EN, PRESCALE=4): TIMEOUT=2, WARN=0 -> EXPIRED after 12 non-halted cycles; kick at cycle 6 restarts the full 12-cycle interval.
